// File: rtl/gonso_wb_pkg.sv
// Shared definitions for the Wishbone burst initiator: FSM encoding, address stride, byte lanes.
package gonso_wb_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WDAT = 3'd1;
    localparam logic [2:0] ST_BUS  = 3'd2;
    localparam logic [2:0] ST_RSP  = 3'd3;
    localparam logic [2:0] ST_ADV  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        WDAT = ST_WDAT,
        BUS  = ST_BUS,
        RSP  = ST_RSP,
        ADV  = ST_ADV
    } wb_state_e;

    localparam logic [31:0] WB_STRIDE  = 32'd4;
    localparam logic [3:0]  WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts bus cycles without an acknowledge; expired fires on the increment that reaches TIMEOUT.
module wb_timeout_counter #(
    parameter int TSIZE   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [TSIZE-1:0] LAST = TSIZE'(TIMEOUT - 1);

    logic [TSIZE-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_q + 1'b1;
    end

    assign expired = inc && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wb_burst_initiator.sv
// Wishbone classic initiator: one command becomes cmd_len+1 single 32-bit transfers.
// Define WB_TIMEOUT_EN to abort a transfer that sees no ack for TIMEOUT bus cycles.
module wb_burst_initiator
    import gonso_wb_pkg::*;
#(
    parameter int LSIZE   = 8,
    parameter int TSIZE   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [LSIZE-1:0] cmd_len,
    input  logic             wdat_valid,
    output logic             wdat_ready,
    input  logic [31:0]      wdat,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             done,
    output logic             err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    output logic [3:0]       wbm_sel_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);

    wb_state_e        state_q, state_d;
    logic [31:0]      adr_q, adr_d;
    logic             we_q, we_d;
    logic [LSIZE-1:0] rem_q, rem_d;
    logic             bus_q, bus_d;
    logic             wb_we_q, wb_we_d;
    logic [31:0]      wb_adr_q, wb_adr_d;
    logic [31:0]      wb_dat_q, wb_dat_d;
    logic [3:0]       wb_sel_q, wb_sel_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             done_q, done_d;
    logic             tmo_expired;

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        we_d        = we_q;
        rem_d       = rem_q;
        wb_dat_d    = wb_dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    adr_d   = cmd_adr;
                    we_d    = cmd_we;
                    rem_d   = cmd_len;
                    state_d = cmd_we ? WDAT : BUS;
                end
            end
            WDAT: begin
                if (wdat_valid) begin
                    wb_dat_d = wdat;
                    state_d  = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    if (we_q) begin
                        state_d = ADV;
                    end else begin
                        rsp_data_d  = wbm_dat_i;
                        rsp_valid_d = 1'b1;
                        state_d     = RSP;
                    end
                end else if (tmo_expired) begin
                    // Abort discards the remaining words of the burst.
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ADV;
                end
            end
            ADV: begin
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    rem_d   = rem_q - 1'b1;
                    adr_d   = adr_q + WB_STRIDE;
                    state_d = we_q ? WDAT : BUS;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered from the next state so stb rises the cycle BUS is entered.
        bus_d    = (state_d == BUS);
        wb_we_d  = bus_d && we_d;
        wb_sel_d = bus_d ? WB_SEL_ALL : 4'h0;
        wb_adr_d = bus_d ? adr_d : wb_adr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            we_q        <= 1'b0;
            rem_q       <= '0;
            bus_q       <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_adr_q    <= '0;
            wb_dat_q    <= '0;
            wb_sel_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            rem_q       <= rem_d;
            bus_q       <= bus_d;
            wb_we_q     <= wb_we_d;
            wb_adr_q    <= wb_adr_d;
            wb_dat_q    <= wb_dat_d;
            wb_sel_q    <= wb_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            done_q      <= done_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    logic tmo_clr, tmo_inc;
    logic err_q, err_d;

    assign tmo_clr = (state_q != BUS);
    assign tmo_inc = (state_q == BUS) && !wbm_ack_i;
    assign err_d   = tmo_expired;

    wb_timeout_counter #(
        .TSIZE   (TSIZE),
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .inc     (tmo_inc),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err = err_q;
`else
    assign tmo_expired = 1'b0;
    assign err         = 1'b0;
`endif

    assign cmd_ready  = (state_q == IDLE);
    assign wdat_ready = (state_q == WDAT);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign done       = done_q;
    assign wbm_cyc_o  = bus_q;
    assign wbm_stb_o  = bus_q;
    assign wbm_we_o   = wb_we_q;
    assign wbm_adr_o  = wb_adr_q;
    assign wbm_dat_o  = wb_dat_q;
    assign wbm_sel_o  = wb_sel_q;

endmodule

// File: tb/tb_wb_burst_initiator.sv
// Directed bench for wb_burst_initiator: single-word vector table plus burst, backpressure,
// reset, address-wrap and (with WB_TIMEOUT_EN) timeout sequences against a registered-ack responder.
module tb_wb_burst_initiator;

`ifdef WB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 1023;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [7:0]  cmd_len;
    logic        wdat_valid, wdat_ready;
    logic [31:0] wdat;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        done, err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;

    always #5 clk = ~clk;

    wb_burst_initiator #(.LSIZE(8), .TSIZE(16), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .done(done), .err(err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Responder: registered ack after ack_delay wait cycles; read data = adr ^ 5A5A5A5A.
    logic ack_en = 1'b1;
    int   ack_delay = 0;
    int   wcnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wbm_ack_i <= 1'b0;
            wbm_dat_i <= '0;
            wcnt      <= 0;
        end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
            if (ack_en && wcnt >= ack_delay) begin
                wbm_ack_i <= 1'b1;
                wbm_dat_i <= wbm_adr_o ^ 32'h5A5A_5A5A;
                wcnt      <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wbm_ack_i <= 1'b0;
        end
    end

    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];
    logic [3:0]  log_sel[$];
    logic [31:0] rsp_q[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          viol = 0;
    logic        ack_seen = 1'b0;

    always @(negedge clk) begin
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
            log_adr.push_back(wbm_adr_o);
            log_dat.push_back(wbm_dat_o);
            log_we.push_back(wbm_we_o);
            log_sel.push_back(wbm_sel_o);
        end
        if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (ack_seen && wbm_cyc_o) viol++;
        if (wbm_stb_o != wbm_cyc_o) viol++;
        if (!wbm_stb_o && (wbm_we_o || wbm_sel_o != 4'h0)) viol++;
        if (rsp_valid && wbm_stb_o) viol++;
        ack_seen = wbm_cyc_o && wbm_stb_o && wbm_ack_i;
    end

    logic [31:0] wq[8];
    int          widx;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        log_adr.delete(); log_dat.delete(); log_we.delete(); log_sel.delete(); rsp_q.delete();
    endtask

    task automatic start_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len);
        widx = 0;
        wdat = wq[0];
        cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic step_wdat;
        bit hs;
        hs = wdat_valid && wdat_ready;
        tick;
        if (hs) begin
            widx++;
            if (widx < 8) wdat = wq[widx];
        end
    endtask

    task automatic run(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            step_wdat;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        tick;
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        int          dly;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vt[6];

    initial begin
        bit ok, found;
        int d0, n;
        logic [31:0] held;

        vt[0] = '{1'b1, 32'h3000_0004, 32'h1234_5678, 0, 32'h1234_5678};
        vt[1] = '{1'b0, 32'h3000_0010, 32'h0,         0, 32'h6A5A_5A4A};
        vt[2] = '{1'b1, 32'h3000_0008, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF};
        vt[3] = '{1'b0, 32'h0000_0000, 32'h0,         3, 32'h5A5A_5A5A};
        vt[4] = '{1'b0, 32'h8000_0100, 32'h0,         1, 32'hDA5A_5B5A};
        vt[5] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 0, 32'h0000_0000};

        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
        wdat_valid = 1'b1; wdat = '0; rsp_ready = 1'b1; widx = 0;
        for (int i = 0; i < 8; i++) wq[i] = '0;
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_done", done, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_wdat_ready", wdat_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        tick;

        // Single-word vectors
        for (int v = 0; v < 6; v++) begin
            clear_logs();
            ack_delay = vt[v].dly;
            wq[0] = vt[v].wd;
            d0 = done_cnt;
            start_cmd(vt[v].we, vt[v].adr, 8'd0);
            run(40, ok);
            check($sformatf("v%0d_done", v), ok, 1);
            check($sformatf("v%0d_done_cnt", v), done_cnt - d0, 1);
            check($sformatf("v%0d_xfers", v), log_adr.size(), 1);
            check($sformatf("v%0d_adr", v), qat(log_adr, 0), vt[v].adr);
            check($sformatf("v%0d_we", v), (log_we.size() > 0) ? log_we[0] : 1'bx, vt[v].we);
            check($sformatf("v%0d_sel", v), (log_sel.size() > 0) ? log_sel[0] : 4'hx, 4'hF);
            if (vt[v].we) check($sformatf("v%0d_wdat", v), qat(log_dat, 0), vt[v].exp_dat);
            else          check($sformatf("v%0d_rdat", v), qat(rsp_q, 0), vt[v].exp_dat);
        end

        // Minimum single-read latency: stb t1, ack t2, rsp_valid t3
        clear_logs();
        ack_delay = 0;
        start_cmd(1'b0, 32'h3000_0020, 8'd0);
        check("lat_t1_stb", wbm_stb_o, 1);
        check("lat_t1_adr", wbm_adr_o, 32'h3000_0020);
        check("lat_t1_we", wbm_we_o, 0);
        check("lat_t1_cmd_ready", cmd_ready, 0);
        tick;
        check("lat_t2_ack", wbm_ack_i, 1);
        check("lat_t2_rsp_valid", rsp_valid, 0);
        tick;
        check("lat_t3_rsp_valid", rsp_valid, 1);
        check("lat_t3_rsp_data", rsp_data, 32'h6A5A_5A7A);
        check("lat_t3_cyc", wbm_cyc_o, 0);
        tick;
        check("lat_t4_rsp_valid", rsp_valid, 0);
        tick;
        check("lat_t5_done", done, 1);
        tick;
        check("lat_t6_done", done, 0);

        // Read burst len 3, one wait cycle per transfer
        clear_logs();
        ack_delay = 1;
        d0 = done_cnt;
        start_cmd(1'b0, 32'h3000_1000, 8'd3);
        run(80, ok);
        check("rb_done", ok, 1);
        check("rb_done_cnt", done_cnt - d0, 1);
        check("rb_xfers", log_adr.size(), 4);
        check("rb_adr0", qat(log_adr, 0), 32'h3000_1000);
        check("rb_adr1", qat(log_adr, 1), 32'h3000_1004);
        check("rb_adr2", qat(log_adr, 2), 32'h3000_1008);
        check("rb_adr3", qat(log_adr, 3), 32'h3000_100C);
        check("rb_dat0", qat(rsp_q, 0), 32'h6A5A_4A5A);
        check("rb_dat1", qat(rsp_q, 1), 32'h6A5A_4A5E);
        check("rb_dat2", qat(rsp_q, 2), 32'h6A5A_4A52);
        check("rb_dat3", qat(rsp_q, 3), 32'h6A5A_4A56);

        // Write burst len 2
        clear_logs();
        ack_delay = 0;
        wq[0] = 32'h1111_1111; wq[1] = 32'h2222_2222; wq[2] = 32'h3333_3333;
        start_cmd(1'b1, 32'h3000_2000, 8'd2);
        run(80, ok);
        check("wb_done", ok, 1);
        check("wb_xfers", log_adr.size(), 3);
        check("wb_adr2", qat(log_adr, 2), 32'h3000_2008);
        check("wb_dat0", qat(log_dat, 0), 32'h1111_1111);
        check("wb_dat1", qat(log_dat, 1), 32'h2222_2222);
        check("wb_dat2", qat(log_dat, 2), 32'h3333_3333);

        // Response backpressure: rsp held for 5 cycles, no new stb meanwhile
        clear_logs();
        rsp_ready = 1'b0;
        start_cmd(1'b0, 32'h3000_0040, 8'd1);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) begin found = 1'b1; break; end
            tick;
        end
        check("bp_rsp_seen", found, 1);
        held = rsp_data;
        check("bp_data", held, 32'h6A5A_5A1A);
        for (int c = 0; c < 5; c++) begin
            tick;
            check($sformatf("bp_valid_%0d", c), rsp_valid, 1);
            check($sformatf("bp_stable_%0d", c), rsp_data, held);
            check($sformatf("bp_no_stb_%0d", c), wbm_stb_o, 0);
        end
        check("bp_xfers_held", log_adr.size(), 1);
        rsp_ready = 1'b1;
        run(40, ok);
        check("bp_done", ok, 1);
        check("bp_xfers", log_adr.size(), 2);
        check("bp_adr1", qat(log_adr, 1), 32'h3000_0044);
        check("bp_dat1", qat(rsp_q, 1), 32'h6A5A_5A1E);

        // Reset during the second word of a len 3 write
        clear_logs();
        wq[0] = 32'hA000_0000; wq[1] = 32'hA111_1111; wq[2] = 32'hA222_2222; wq[3] = 32'hA333_3333;
        start_cmd(1'b1, 32'h3000_3000, 8'd3);
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (log_adr.size() == 1 && wbm_stb_o) begin found = 1'b1; break; end
            step_wdat;
        end
        check("rr_second_stb", found, 1);
        check("rr_second_dat", wbm_dat_o, 32'hA111_1111);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("rr_cyc", wbm_cyc_o, 0);
        check("rr_stb", wbm_stb_o, 0);
        check("rr_we", wbm_we_o, 0);
        check("rr_sel", wbm_sel_o, 0);
        check("rr_dat_o", wbm_dat_o, 0);
        check("rr_cmd_ready", cmd_ready, 1);
        check("rr_wdat_ready", wdat_ready, 0);
        check("rr_done", done, 0);
        tick;
        rst = 1'b0;
        tick; tick; tick;
        check("rr_no_done", done_cnt - d0, 0);
        clear_logs();
        start_cmd(1'b0, 32'h3000_0000, 8'd0);
        run(40, ok);
        check("rr_new_done", ok, 1);
        check("rr_new_dat", qat(rsp_q, 0), 32'h6A5A_5A5A);
        check("rr_new_cnt", done_cnt - d0, 1);

        // Address wrap
        clear_logs();
        start_cmd(1'b0, 32'hFFFF_FFFC, 8'd1);
        run(40, ok);
        check("wr_done", ok, 1);
        check("wr_adr0", qat(log_adr, 0), 32'hFFFF_FFFC);
        check("wr_adr1", qat(log_adr, 1), 32'h0000_0000);
        check("wr_dat0", qat(rsp_q, 0), 32'hA5A5_A5A6);
        check("wr_dat1", qat(rsp_q, 1), 32'h5A5A_5A5A);

`ifdef WB_TIMEOUT_EN
        // Timeout with a silent responder
        ack_en = 1'b0;
        start_cmd(1'b0, 32'h3000_0100, 8'd2);
        n = 0;
        while (wbm_stb_o && n < 50) begin
            n++;
            tick;
        end
        check("to_stb_cycles", n, TB_TIMEOUT);
        check("to_done", done, 1);
        check("to_err", err, 1);
        check("to_cmd_ready", cmd_ready, 1);
        tick;
        check("to_done_clr", done, 0);
        check("to_err_clr", err, 0);
        ack_en = 1'b1;
        check("to_err_cnt", err_cnt, 1);
`else
        check("no_err", err_cnt, 0);
`endif

        check("protocol_viol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, %0d/%0d checks so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
